// File: rtl/traffic_request_conditioner.sv
// Conditions raw field inputs into clean request levels for the traffic light controller.
// Optional macro TLC_PED_TIMEOUT_EN adds an automatic clear of a stale pedestrian request.
module traffic_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 50,
  parameter int DENSITY_THRESH  = 3,
  parameter int CNT_W           = 8,
  parameter int EMG_HOLD_CYCLES = 8,
  parameter int PED_TIMEOUT     = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_btn_raw,
  input  logic ped_served,
  input  logic emg_raw,
  input  logic ns_car_pulse,
  input  logic we_car_pulse,
  output logic pedestrian,
  output logic emergency,
  output logic NSdensity,
  output logic WEdensity,
  output logic window_tick
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int HOLD_W = $clog2(EMG_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W:0]   THRESH_EXT = (CNT_W+1)'(DENSITY_THRESH);

  if (DEBOUNCE_CYCLES < 2 || WINDOW_CYCLES < 2 || EMG_HOLD_CYCLES < 1 || PED_TIMEOUT < 1)
  begin : g_bad_params
    $error("traffic_request_conditioner: illegal parameter value");
  end

  logic btn_s1, btn_s2, emg_s1, emg_s2;
  logic ns_s1, ns_s2, ns_d, we_s1, we_s2, we_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      emg_s1 <= 1'b0;
      emg_s2 <= 1'b0;
      ns_s1  <= 1'b0;
      ns_s2  <= 1'b0;
      we_s1  <= 1'b0;
      we_s2  <= 1'b0;
    end else begin
      btn_s1 <= ped_btn_raw;
      btn_s2 <= btn_s1;
      emg_s1 <= emg_raw;
      emg_s2 <= emg_s1;
      ns_s1  <= ns_car_pulse;
      ns_s2  <= ns_s1;
      we_s1  <= we_car_pulse;
      we_s2  <= we_s1;
    end
  end

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  logic            db, db_d;
  logic [DB_W-1:0] db_cnt;
  logic            ped_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= '0;
    end else begin
      db_d <= db;
      if (btn_s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db     <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign ped_set = db && !db_d;

`ifdef TLC_PED_TIMEOUT_EN
  localparam int PTO_W = $clog2(PED_TIMEOUT + 1);
  logic [PTO_W-1:0] ped_age;

  always_ff @(posedge clk) begin
    if (reset) begin
      pedestrian <= 1'b0;
      ped_age    <= '0;
    end else if (ped_set) begin
      pedestrian <= 1'b1;
      ped_age    <= '0;
    end else if (ped_served || (pedestrian && ped_age == PTO_W'(PED_TIMEOUT - 1))) begin
      pedestrian <= 1'b0;
      ped_age    <= '0;
    end else if (pedestrian) begin
      ped_age <= ped_age + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      pedestrian <= 1'b0;
    end else if (ped_set) begin
      pedestrian <= 1'b1;
    end else if (ped_served) begin
      pedestrian <= 1'b0;
    end
  end
`endif

  // Hold timer is reloaded while the line is high, so it starts its countdown on the fall.
  logic [HOLD_W-1:0] emg_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      emg_hold <= '0;
    end else if (emg_s2) begin
      emg_hold <= HOLD_W'(EMG_HOLD_CYCLES);
    end else if (emg_hold != '0) begin
      emg_hold <= emg_hold - 1'b1;
    end
  end

  // OR of two flops: follows the synchronised line with no gap and no input-to-output path.
  assign emergency = emg_s2 || (emg_hold != '0);

  logic [WIN_W-1:0] win_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt     <= '0;
      window_tick <= 1'b0;
    end else begin
      window_tick <= (win_cnt == WIN_W'(WINDOW_CYCLES - 2));
      win_cnt     <= (win_cnt == WIN_W'(WINDOW_CYCLES - 1)) ? '0 : win_cnt + 1'b1;
    end
  end

  logic             ns_rise, we_rise;
  logic [CNT_W-1:0] ns_cnt, we_cnt;
  logic [CNT_W:0]   ns_total, we_total;

  assign ns_rise  = ns_s2 && !ns_d;
  assign we_rise  = we_s2 && !we_d;
  assign ns_total = {1'b0, ns_cnt} + {{CNT_W{1'b0}}, ns_rise};
  assign we_total = {1'b0, we_cnt} + {{CNT_W{1'b0}}, we_rise};

  // An edge landing on the tick cycle still belongs to the window that is closing.
  always_ff @(posedge clk) begin
    if (reset) begin
      ns_d      <= 1'b0;
      we_d      <= 1'b0;
      ns_cnt    <= '0;
      we_cnt    <= '0;
      NSdensity <= 1'b0;
      WEdensity <= 1'b0;
    end else begin
      ns_d <= ns_s2;
      we_d <= we_s2;
      if (window_tick) begin
        NSdensity <= (ns_total >= THRESH_EXT);
        WEdensity <= (we_total >= THRESH_EXT);
        ns_cnt    <= '0;
        we_cnt    <= '0;
      end else begin
        if (ns_rise && ns_cnt != CNT_MAX) ns_cnt <= ns_cnt + 1'b1;
        if (we_rise && we_cnt != CNT_MAX) we_cnt <= we_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Self-checking bench for traffic_request_conditioner: directed scenarios plus random
// traffic compared against a cycle-history reference model (honours TLC_PED_TIMEOUT_EN).
module tb_traffic_request_conditioner;

  localparam int DB   = 4;
  localparam int WIN  = 50;
  localparam int TH   = 3;
  localparam int CW   = 8;
  localparam int HOLD = 8;
  localparam int PTO  = 200;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ped_btn_raw = 1'b0;
  logic ped_served = 1'b0;
  logic emg_raw = 1'b0;
  logic ns_car_pulse = 1'b0;
  logic we_car_pulse = 1'b0;
  logic pedestrian, emergency, NSdensity, WEdensity, window_tick;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_request_conditioner #(
    .DEBOUNCE_CYCLES(DB), .WINDOW_CYCLES(WIN), .DENSITY_THRESH(TH),
    .CNT_W(CW), .EMG_HOLD_CYCLES(HOLD), .PED_TIMEOUT(PTO)
  ) dut (
    .clk(clk), .reset(reset), .ped_btn_raw(ped_btn_raw), .ped_served(ped_served),
    .emg_raw(emg_raw), .ns_car_pulse(ns_car_pulse), .we_car_pulse(we_car_pulse),
    .pedestrian(pedestrian), .emergency(emergency), .NSdensity(NSdensity),
    .WEdensity(WEdensity), .window_tick(window_tick)
  );

  always #5 clk = ~clk;

  // Reference model: raw input history per cycle since reset; expected outputs for the next cycle.
  int cyc = 0;
  bit raw_in [4][MAXC];
  bit m_db, m_db_prev;
  int m_run, ped_set_cyc, ns_cnt, we_cnt;
  bit exp_ped, exp_emg, exp_ns, exp_we, exp_tick;

  function automatic bit syn(int ch, int c);
    if (c < 2 || c - 2 >= MAXC) return 1'b0;
    return raw_in[ch][c-2];
  endfunction

  always @(posedge clk) begin : model
    bit db_now, any_emg;
    int n;
    if (reset) begin
      cyc = 0; m_db = 0; m_db_prev = 0; m_run = 0; ped_set_cyc = 0;
      ns_cnt = 0; we_cnt = 0;
      exp_ped = 0; exp_emg = 0; exp_ns = 0; exp_we = 0; exp_tick = 0;
    end else begin
      if (cyc < MAXC) begin
        raw_in[0][cyc] = ped_btn_raw;
        raw_in[1][cyc] = emg_raw;
        raw_in[2][cyc] = ns_car_pulse;
        raw_in[3][cyc] = we_car_pulse;
      end
      n = cyc + 1;
      db_now = m_db;
      if (syn(0, cyc) != m_db) begin
        m_run++;
        if (m_run == DB) begin
          m_db = syn(0, cyc);
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (db_now && !m_db_prev) begin
        exp_ped = 1;
        ped_set_cyc = n;
      end else if (ped_served) begin
        exp_ped = 0;
`ifdef TLC_PED_TIMEOUT_EN
      end else if (exp_ped && (n - ped_set_cyc) >= PTO) begin
        exp_ped = 0;
`endif
      end
      m_db_prev = db_now;
      any_emg = 0;
      for (int k = n - HOLD; k <= n; k++) any_emg |= syn(1, k);
      exp_emg = any_emg;
      ns_cnt += int'(syn(2, cyc) && !syn(2, cyc - 1));
      we_cnt += int'(syn(3, cyc) && !syn(3, cyc - 1));
      if (cyc % WIN == WIN - 1) begin
        exp_ns = (ns_cnt >= TH);
        exp_we = (we_cnt >= TH);
        ns_cnt = 0;
        we_cnt = 0;
      end
      exp_tick = (n % WIN == WIN - 1);
      cyc = n;
    end
  end

  task automatic idle_inputs();
    ped_btn_raw = 0; ped_served = 0; emg_raw = 0; ns_car_pulse = 0; we_car_pulse = 0;
  endtask

  task automatic wait_window_start();
    for (int k = 0; k < 2 * WIN && (cyc % WIN) != 0; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    for (int k = 0; k < 100; k++) begin
      n_cmp++;
      if ({pedestrian, emergency, NSdensity, WEdensity} !== 4'b0000) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs: cycle %0d got %b%b%b%b expected 0000", k,
                 pedestrian, emergency, NSdensity, WEdensity);
      end
      n_cmp++;
      if (window_tick !== (k == 49 || k == 99)) begin
        n_bad++;
        $display("[TB] FAIL reset_tick: cycle %0d window_tick=%b expected %b", k, window_tick,
                 (k == 49 || k == 99));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ped_press();
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (pedestrian !== (i >= 7)) begin
        n_bad++;
        $display("[TB] FAIL ped_latency: offset %0d pedestrian=%b expected %b", i, pedestrian, (i >= 7));
      end
      ped_btn_raw = 1;
      @(negedge clk);
    end
    ped_btn_raw = 0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (pedestrian !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL ped_latched: offset %0d pedestrian=%b expected 1", i, pedestrian);
      end
      @(negedge clk);
    end
    ped_served = 1;
    @(negedge clk);
    ped_served = 0;
    n_cmp++;
    if (pedestrian !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ped_served_clear: pedestrian=%b expected 0", pedestrian);
    end
    for (int i = 0; i < 18; i++) begin
      ped_btn_raw = (i < 3);
      @(negedge clk);
      n_cmp++;
      if (pedestrian !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL ped_glitch: offset %0d pedestrian=%b expected 0", i, pedestrian);
      end
    end
  endtask

  task automatic test_set_and_served();
    for (int i = 0; i < 60; i++) begin
      n_cmp++;
      if (pedestrian !== (i >= 7 && i <= 30)) begin
        n_bad++;
        $display("[TB] FAIL ped_set_wins_hold: offset %0d pedestrian=%b expected %b", i, pedestrian,
                 (i >= 7 && i <= 30));
      end
      ped_btn_raw = (i < 50);
      ped_served  = (i == 6 || i == 30);
      @(negedge clk);
    end
    ped_served = 0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (pedestrian !== (i >= 7)) begin
        n_bad++;
        $display("[TB] FAIL ped_repress: offset %0d pedestrian=%b expected %b", i, pedestrian, (i >= 7));
      end
      ped_btn_raw = 1;
      @(negedge clk);
    end
    ped_btn_raw = 0;
    ped_served = 1;
    @(negedge clk);
    ped_served = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_density();
    wait_window_start();
    for (int i = 0; i <= 100; i++) begin
      if (i == 49) begin
        n_cmp++;
        if (window_tick !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL density_tick: window_tick=%b expected 1", window_tick);
        end
      end
      if (i == 50) begin
        n_cmp++;
        if ({NSdensity, WEdensity} !== 2'b10) begin
          n_bad++;
          $display("[TB] FAIL density_busy: NS/WE=%b%b expected 10", NSdensity, WEdensity);
        end
      end
      if (i == 100) begin
        n_cmp++;
        if ({NSdensity, WEdensity} !== 2'b00) begin
          n_bad++;
          $display("[TB] FAIL density_quiet: NS/WE=%b%b expected 00", NSdensity, WEdensity);
        end
      end
      ns_car_pulse = (i >= 5 && i < 7) || (i >= 20 && i < 23) || (i >= 47 && i < 50);
      we_car_pulse = (i >= 10 && i < 12) || (i >= 30 && i < 32);
      @(negedge clk);
    end
  endtask

  task automatic test_emergency();
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (emergency !== (i >= 2 && i <= 19)) begin
        n_bad++;
        $display("[TB] FAIL emg_stretch: offset %0d emergency=%b expected %b", i, emergency,
                 (i >= 2 && i <= 19));
      end
      emg_raw = (i < 10);
      @(negedge clk);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (emergency !== (i >= 2 && i <= 25)) begin
        n_bad++;
        $display("[TB] FAIL emg_repulse: offset %0d emergency=%b expected %b", i, emergency,
                 (i >= 2 && i <= 25));
      end
      emg_raw = (i < 10) || (i >= 14 && i < 16);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_window();
    wait_window_start();
    for (int i = 0; i < 26; i++) begin
      if (i == 23) begin
        n_cmp++;
        if ({pedestrian, emergency} !== 2'b11) begin
          n_bad++;
          $display("[TB] FAIL pre_reset_state: ped/emg=%b%b expected 11", pedestrian, emergency);
        end
      end
      ped_btn_raw  = (i < 8);
      ns_car_pulse = (i >= 5 && i < 7) || (i >= 15 && i < 17);
      emg_raw      = (i >= 18 && i < 23);
      reset        = (i >= 24);
      @(negedge clk);
    end
    reset = 0;
    idle_inputs();
    n_cmp++;
    if ({pedestrian, emergency, NSdensity, WEdensity, window_tick} !== 5'b00000) begin
      n_bad++;
      $display("[TB] FAIL midreset_outputs: got %b%b%b%b%b expected 00000", pedestrian, emergency,
               NSdensity, WEdensity, window_tick);
    end
    for (int j = 0; j <= 50; j++) begin
      if (j == 50) begin
        n_cmp++;
        if (NSdensity !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL midreset_discard: NSdensity=%b expected 0", NSdensity);
        end
      end
      ns_car_pulse = (j >= 10 && j < 12);
      @(negedge clk);
    end
  endtask

  task automatic test_ped_timeout();
`ifdef TLC_PED_TIMEOUT_EN
    for (int i = 0; i < 212; i++) begin
      if (i == 206 || i == 207) begin
        n_cmp++;
        if (pedestrian !== (i == 206)) begin
          n_bad++;
          $display("[TB] FAIL ped_timeout: offset %0d pedestrian=%b expected %b", i, pedestrian, (i == 206));
        end
      end
      ped_btn_raw = (i < 10);
      @(negedge clk);
    end
`else
    for (int i = 0; i < 252; i++) begin
      if (i == 250) begin
        n_cmp++;
        if (pedestrian !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL ped_no_timeout: pedestrian=%b expected 1", pedestrian);
        end
      end
      ped_btn_raw = (i < 10);
      @(negedge clk);
    end
    ped_served = 1;
    @(negedge clk);
    ped_served = 0;
`endif
  endtask

  task automatic test_random();
    int ns_len = 0;
    int we_len = 0;
    for (int i = 0; i < 1500; i++) begin
      n_cmp++;
      if (pedestrian !== exp_ped) begin
        n_bad++;
        $display("[TB] FAIL rnd_ped: cycle %0d got %b expected %b", cyc, pedestrian, exp_ped);
      end
      n_cmp++;
      if (emergency !== exp_emg) begin
        n_bad++;
        $display("[TB] FAIL rnd_emg: cycle %0d got %b expected %b", cyc, emergency, exp_emg);
      end
      n_cmp++;
      if ({NSdensity, WEdensity} !== {exp_ns, exp_we}) begin
        n_bad++;
        $display("[TB] FAIL rnd_density: cycle %0d got %b%b expected %b%b", cyc, NSdensity, WEdensity,
                 exp_ns, exp_we);
      end
      n_cmp++;
      if (window_tick !== exp_tick) begin
        n_bad++;
        $display("[TB] FAIL rnd_tick: cycle %0d got %b expected %b", cyc, window_tick, exp_tick);
      end
      if ($urandom_range(0, 5) == 0) ped_btn_raw = ~ped_btn_raw;
      ped_served = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 14) == 0) emg_raw = ~emg_raw;
      if (ns_len > 0) begin
        ns_car_pulse = 1; ns_len--;
      end else begin
        ns_car_pulse = 0;
        if ($urandom_range(0, 11) == 0) ns_len = $urandom_range(2, 4);
      end
      if (we_len > 0) begin
        we_car_pulse = 1; we_len--;
      end else begin
        we_car_pulse = 0;
        if ($urandom_range(0, 5) == 0) we_len = $urandom_range(2, 4);
      end
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ped_press();
    test_set_and_served();
    test_density();
    test_emergency();
    test_reset_mid_window();
    test_ped_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
